mmio_wsel: RTL and testbench

- Store-side address decoder and MMIO register block for the RISC-V core; the write-direction counterpart of the load-data select.
- Takes the MEM-stage store (address, data, byte mask).
- Steers byte write enables to DMEM/IMEM and performs MMIO side effects: UART transmit handshake, counter clear, button-FIFO pop, LED register.
- Owns the cycle and instruction counters and the UART-tx pending state that the read side returns.

---
 rtl/mmio_wsel_if.sv | 12 +
 rtl/mmio_wsel.sv | 122 ++++++++++++
 tb/tb_mmio_wsel.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_wsel_if.sv
// Store bus and UART transmit handshake shared between the MEM stage and mmio_wsel.
interface mmio_wsel_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  we;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output addr, din, we, tx_ready, input tx_data, tx_valid);
  modport slave  (input addr, din, we, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/mmio_wsel.sv
// Store-side address decode, memory write enables and MMIO register block (UART tx, counters, buttons, LEDs).
// Optional sticky bus-error flag enabled by defining MMIO_BUS_ERR_EN.
module mmio_wsel #(
  parameter int unsigned LED_W = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mmio_wsel_if.slave       bus,
  input  logic             pc_in_bios,
  input  logic             inst_retire,
  output logic [3:0]       dmem_wea,
  output logic [3:0]       imem_wea,
  output logic             trmt_full,
  output logic [CNT_W-1:0] counter_cycle,
  output logic [CNT_W-1:0] counter_inst,
  output logic             buttons_rd_en,
  output logic [LED_W-1:0] leds
`ifdef MMIO_BUS_ERR_EN
  ,
  output logic             bus_err
`endif
);

  typedef enum logic {TX_IDLE, TX_PEND} tx_state_t;

  tx_state_t  tx_state, tx_next;
  logic       store;
  logic [3:0] region;
  logic [3:0] offset;
  logic       is_mmio;
  logic       wr_uart, wr_clear, wr_pop, wr_led;
  logic       uart_accept;
  logic [7:0] tx_data_q;
  logic       unused_bits;

  assign store   = |bus.we;
  assign region  = bus.addr[31:28];
  assign offset  = bus.addr[5:2];
  assign is_mmio = store && (region == 4'h8);

  assign wr_uart  = is_mmio && (offset == 4'h2);
  assign wr_clear = is_mmio && (offset == 4'h6);
  assign wr_pop   = is_mmio && (offset == 4'h9);
  assign wr_led   = is_mmio && (offset == 4'hC);

  // Only an idle transmitter takes a byte; this also drops stores in the acceptance cycle.
  assign uart_accept = wr_uart && (tx_state == TX_IDLE);

  assign unused_bits = ^{bus.din[31:8], bus.addr[27:6], bus.addr[1:0]};

  always_comb begin
    dmem_wea = '0;
    imem_wea = '0;
    if (store && ((region == 4'h1) || (region == 4'h3)))
      dmem_wea = bus.we;
    if (store && pc_in_bios && ((region == 4'h2) || (region == 4'h3)))
      imem_wea = bus.we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE: if (uart_accept)  tx_next = TX_PEND;
      TX_PEND: if (bus.tx_ready) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_valid = (tx_state == TX_PEND);
    trmt_full    = (tx_state == TX_PEND);
    bus.tx_data  = tx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q     <= '0;
      buttons_rd_en <= 1'b0;
      leds          <= '0;
    end else begin
      if (uart_accept) tx_data_q <= bus.din[7:0];
      buttons_rd_en <= wr_pop;
      if (wr_led) leds <= bus.din[LED_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_cycle <= '0;
      counter_inst  <= '0;
    end else if (wr_clear) begin
      counter_cycle <= '0;
      counter_inst  <= '0;
    end else begin
      counter_cycle <= counter_cycle + CNT_W'(1);
      if (inst_retire) counter_inst <= counter_inst + CNT_W'(1);
    end
  end

`ifdef MMIO_BUS_ERR_EN
  logic err_set, err_clr;

  // BIOS counts as a bad target here, so it is left out of the mapped set.
  assign err_set = store && (!(region inside {4'h1, 4'h2, 4'h3, 4'h8})
                   || (is_mmio && !(offset inside {4'h2, 4'h6, 4'h9, 4'hC, 4'hF}))
                   || (!pc_in_bios && ((region == 4'h2) || (region == 4'h3))));
  assign err_clr = is_mmio && (offset == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bus_err <= 1'b0;
    else if (err_set) bus_err <= 1'b1;
    else if (err_clr) bus_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mmio_wsel.sv
// Self-checking bench for mmio_wsel: constant vector table, directed corner sequences and random stores vs a reference model.
module tb_mmio_wsel;
  logic        clk;
  logic        rst_n;
  logic        pc_in_bios;
  logic        inst_retire;
  logic [3:0]  dmem_wea, imem_wea;
  logic        trmt_full;
  logic [31:0] counter_cycle, counter_inst;
  logic        buttons_rd_en;
  logic [5:0]  leds;
  logic [3:0]  s_dmem, s_imem;
  logic        s_trmt;
  logic [3:0]  s_cycle, s_inst;
  logic        s_btn;
  logic [5:0]  s_leds;
`ifdef MMIO_BUS_ERR_EN
  logic        bus_err, s_err;
`endif

  mmio_wsel_if bus ();
  mmio_wsel_if sbus ();

  mmio_wsel #(.LED_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pc_in_bios(pc_in_bios), .inst_retire(inst_retire),
    .dmem_wea(dmem_wea), .imem_wea(imem_wea), .trmt_full(trmt_full),
    .counter_cycle(counter_cycle), .counter_inst(counter_inst),
    .buttons_rd_en(buttons_rd_en), .leds(leds)
`ifdef MMIO_BUS_ERR_EN
    , .bus_err(bus_err)
`endif
  );

  // Narrow counters so wrap-around is reachable in a short run.
  mmio_wsel #(.LED_W(6), .CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(sbus), .pc_in_bios(1'b0), .inst_retire(1'b1),
    .dmem_wea(s_dmem), .imem_wea(s_imem), .trmt_full(s_trmt),
    .counter_cycle(s_cycle), .counter_inst(s_inst),
    .buttons_rd_en(s_btn), .leds(s_leds)
`ifdef MMIO_BUS_ERR_EN
    , .bus_err(s_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_cycle, m_inst;
  logic [7:0]  tx_q[$];
  logic [7:0]  m_txdata;
  logic        m_btn;
  logic [5:0]  m_leds;
  logic        m_err;
  logic [3:0]  m_small;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic        pc;
    logic [3:0]  dm;
    logic [3:0]  im;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cycle = '0; m_inst = '0; tx_q.delete(); m_txdata = '0;
    m_btn = 1'b0; m_leds = '0; m_err = 1'b0; m_small = '0;
  endtask

  task automatic model_update();
    logic       s, mm, pend, ok_region, set;
    logic [3:0] r, o;
    s  = |bus.we;
    r  = bus.addr[31:28];
    o  = bus.addr[5:2];
    mm = s && (r == 4'h8);
    pend = (tx_q.size() != 0);
    if (pend && bus.tx_ready) void'(tx_q.pop_front());
    if (mm && o == 4'h2 && !pend) begin
      tx_q.push_back(bus.din[7:0]);
      m_txdata = bus.din[7:0];
    end
    if (mm && o == 4'h6) begin
      m_cycle = '0; m_inst = '0;
    end else begin
      m_cycle = m_cycle + 32'd1;
      if (inst_retire) m_inst = m_inst + 32'd1;
    end
    m_btn = mm && (o == 4'h9);
    if (mm && o == 4'hC) m_leds = bus.din[5:0];
    m_small = m_small + 4'd1;
    ok_region = (r == 4'h1) || (r == 4'h2) || (r == 4'h3) || (r == 4'h8);
    set = s && (!ok_region || (mm && !(o inside {4'h2, 4'h6, 4'h9, 4'hC, 4'hF}))
               || (!pc_in_bios && (r == 4'h2 || r == 4'h3)));
    if (set) m_err = 1'b1;
    else if (mm && o == 4'hF) m_err = 1'b0;
  endtask

  task automatic check_comb();
    logic [3:0] r, ed, ei;
    #1;
    r  = bus.addr[31:28];
    ed = ((|bus.we) && (r == 4'h1 || r == 4'h3)) ? bus.we : 4'h0;
    ei = ((|bus.we) && pc_in_bios && (r == 4'h2 || r == 4'h3)) ? bus.we : 4'h0;
    chk("dmem_wea", 32'(dmem_wea), 32'(ed));
    chk("imem_wea", 32'(imem_wea), 32'(ei));
  endtask

  task automatic check_regs();
    chk("tx_valid", 32'(bus.tx_valid), 32'(tx_q.size() != 0));
    chk("trmt_full", 32'(trmt_full), 32'(tx_q.size() != 0));
    chk("tx_data", 32'(bus.tx_data), 32'(m_txdata));
    chk("counter_cycle", counter_cycle, m_cycle);
    chk("counter_inst", counter_inst, m_inst);
    chk("buttons_rd_en", 32'(buttons_rd_en), 32'(m_btn));
    chk("leds", 32'(leds), 32'(m_leds));
    chk("small_cycle", 32'(s_cycle), 32'(m_small));
    chk("small_inst", 32'(s_inst), 32'(m_small));
`ifdef MMIO_BUS_ERR_EN
    chk("bus_err", 32'(bus_err), 32'(m_err));
`endif
  endtask

  // Called at posedge+1 with inputs already driven; returns at the following posedge+1.
  task automatic step();
    check_comb();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    bus.we = 4'h0; bus.addr = '0; bus.din = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_regs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_regs();
    rst_n = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.addr = a; bus.din = d; bus.we = w;
    step();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  offs[5];
    logic [3:0]  regs[7];
    logic [31:0] tmp;
    logic [3:0]  rg;

    vecs[0] = '{32'h1000_0004, 4'b0011, 1'b0, 4'b0011, 4'b0000};
    vecs[1] = '{32'h3000_0000, 4'b1111, 1'b1, 4'b1111, 4'b1111};
    vecs[2] = '{32'h3000_0000, 4'b1111, 1'b0, 4'b1111, 4'b0000};
    vecs[3] = '{32'h2000_0010, 4'b1100, 1'b1, 4'b0000, 4'b1100};
    vecs[4] = '{32'h2000_0010, 4'b1100, 1'b0, 4'b0000, 4'b0000};
    vecs[5] = '{32'h4000_0000, 4'b1111, 1'b1, 4'b0000, 4'b0000};
    vecs[6] = '{32'h5000_0000, 4'b1111, 1'b1, 4'b0000, 4'b0000};
    vecs[7] = '{32'h1000_0000, 4'b0000, 1'b1, 4'b0000, 4'b0000};
    vecs[8] = '{32'h3FFF_FFFC, 4'b1000, 1'b1, 4'b1000, 4'b1000};
    vecs[9] = '{32'h0000_0000, 4'b1111, 1'b1, 4'b0000, 4'b0000};
    offs = '{4'h2, 4'h6, 4'h9, 4'hC, 4'hF};
    regs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'hF};

    rst_n = 1'b0; pc_in_bios = 1'b0; inst_retire = 1'b0;
    idle_inputs(); bus.tx_ready = 1'b0;
    sbus.addr = '0; sbus.din = '0; sbus.we = 4'h0; sbus.tx_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Combinational write-enable table.
    for (int i = 0; i < 10; i++) begin
      bus.addr = vecs[i].addr; bus.we = vecs[i].we; bus.din = 32'hDEAD_BEEF;
      pc_in_bios = vecs[i].pc;
      #1;
      chk("vec_dmem", 32'(dmem_wea), 32'(vecs[i].dm));
      chk("vec_imem", 32'(imem_wea), 32'(vecs[i].im));
      step();
    end
    idle_inputs(); pc_in_bios = 1'b1;

    // UART: held byte, store dropped while pending, store dropped in acceptance cycle.
    do_reset();
    bus.tx_ready = 1'b0;
    store(32'h8000_0008, 32'h0000_0041, 4'b0001);
    chk("uart_valid", 32'(bus.tx_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bus.addr = 32'h8000_0008; bus.din = 32'h42; bus.we = 4'b0001; end
      step();
      idle_inputs();
      chk("uart_hold_data", 32'(bus.tx_data), 32'h41);
      chk("uart_hold_valid", 32'(bus.tx_valid), 32'd1);
    end
    bus.tx_ready = 1'b1;
    bus.addr = 32'h8000_0008; bus.din = 32'h43; bus.we = 4'b1111;
    #1;
    chk("uart_full_in_accept", 32'(trmt_full), 32'd1);
    step();
    idle_inputs(); bus.tx_ready = 1'b0;
    chk("uart_done_valid", 32'(bus.tx_valid), 32'd0);
    chk("uart_done_data", 32'(bus.tx_data), 32'h41);

    // Counters over 100 cycles, narrow-counter wrap, clear beating increment.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 2 == 0);
      step();
      if (i == 14) chk("small_at_15", 32'(s_cycle), 32'd15);
      if (i == 15) chk("small_wrap", 32'(s_cycle), 32'd0);
    end
    chk("cycle_100", counter_cycle, 32'd100);
    chk("inst_50", counter_inst, 32'd50);
    inst_retire = 1'b1;
    store(32'h8000_0018, 32'h0, 4'b1111);
    chk("clear_cycle", counter_cycle, 32'd0);
    chk("clear_inst", counter_inst, 32'd0);
    inst_retire = 1'b0;

    // Button pulse, LED register, BIOS store.
    store(32'h8000_0024, 32'h0, 4'b0001);
    chk("btn_pulse", 32'(buttons_rd_en), 32'd1);
    step();
    chk("btn_pulse_end", 32'(buttons_rd_en), 32'd0);
    store(32'h8000_0030, 32'h0000_002A, 4'b1111);
    chk("leds_2a", 32'(leds), 32'h2A);
    bus.addr = 32'h4000_0000; bus.din = 32'hFFFF_FFFF; bus.we = 4'b1111;
    #1;
    chk("bios_dmem", 32'(dmem_wea), 32'd0);
    chk("bios_imem", 32'(imem_wea), 32'd0);
    step();
    idle_inputs();
    chk("bios_leds", 32'(leds), 32'h2A);
    chk("bios_tx", 32'(bus.tx_valid), 32'd0);
`ifdef MMIO_BUS_ERR_EN
    chk("bios_err", 32'(bus_err), 32'd1);
    store(32'h8000_003C, 32'h0, 4'b0001);
    chk("err_clear", 32'(bus_err), 32'd0);
`endif

    // Asynchronous reset in the middle of a pending transmit.
    store(32'h8000_0008, 32'h0000_0055, 4'b0001);
    chk("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", 32'(bus.tx_valid), 32'd0);
    chk("arst_data", 32'(bus.tx_data), 32'd0);
    chk("arst_leds", 32'(leds), 32'd0);
    chk("arst_cycle", counter_cycle, 32'd0);
    do_reset();
    for (int i = 0; i < 3; i++) step();
    chk("no_retransmit", 32'(bus.tx_valid), 32'd0);

    // Randomised stores against the reference model.
    for (int i = 0; i < 400; i++) begin
      rg  = regs[$urandom_range(0, 6)];
      tmp = $urandom();
      bus.addr = {rg, tmp[27:0]};
      if (rg == 4'h8 && $urandom_range(0, 3) != 0) bus.addr[5:2] = offs[$urandom_range(0, 4)];
      bus.din = $urandom();
      tmp = $urandom();
      bus.we = ($urandom_range(0, 3) == 0) ? 4'h0 : tmp[3:0];
      pc_in_bios   = $urandom_range(0, 1) != 0;
      inst_retire  = $urandom_range(0, 1) != 0;
      bus.tx_ready = $urandom_range(0, 3) == 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
